// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: {Bout,diff} = in1 - in2 - Bin over WIDTH cycles.
// Define SERSUB_OVF_EN to add the signed overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic d;
  logic bnext;
  logic last;

  assign d     = a_sh[0] ^ b_sh[0] ^ borrow;
  assign bnext = (~a_sh[0] & b_sh[0])
               | (~(a_sh[0] ^ b_sh[0]) & borrow);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      Bout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
`ifdef SERSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= in1;
            b_sh   <= in2;
            borrow <= Bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          diff   <= {d, diff[WIDTH-1:1]};
          borrow <= bnext;
          cnt    <= cnt + 1'b1;
          if (last) begin
            Bout  <= bnext;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERSUB_OVF_EN
            // on the last edge the shifters hold the operand MSBs
            ovf   <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Table vectors, handshake corner cases and random ops vs arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         Bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         Bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .Bout  (Bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int dcnt = 0;

  always @(negedge clk) if (done) dcnt++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return r[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic bi);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  logic got_ov;

  // one full operation: checks latency, busy span and single done pulse
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input string nm,
                        output logic [W-1:0] gd, output logic gb);
    int n;
    int bc;
    int d0;
    @(negedge clk);
    in1 = a; in2 = b; Bin = bi; start = 1'b1;
    d0 = dcnt;
    @(negedge clk);
    start = 1'b0;
    in1 = ~a; in2 = ~b; Bin = ~bi;
    n = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    if (busy) bc++;
    chk({nm, ".lat"}, n, W);
    gd = diff;
    gb = Bout;
`ifdef SERSUB_OVF_EN
    got_ov = ovf;
`else
    got_ov = 1'b0;
`endif
    @(negedge clk);
    chk({nm, ".idle"}, {busy, done}, 0);
    chk({nm, ".busyspan"}, bc, W + 1);
    chk({nm, ".pulses"}, dcnt - d0, 1);
  endtask

  initial begin
    logic [W-1:0] gd;
    logic         gb;
    logic [W:0]   exp;
    int           n;
    int           d0;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset", {busy, done, diff, Bout}, 0);
`ifdef SERSUB_OVF_EN
    chk("reset.ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bi, $sformatf("tbl%0d", i), gd, gb);
      chk($sformatf("tbl%0d.diff", i), gd, tbl[i].d);
      chk($sformatf("tbl%0d.bout", i), gb, tbl[i].bo);
`ifdef SERSUB_OVF_EN
      chk($sformatf("tbl%0d.ovf", i), got_ov, tbl[i].ov);
`endif
    end

    // held start with operands changed mid-shift, then re-accept at k+10
    @(negedge clk);
    in1 = 8'hFF; in2 = 8'hFF; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("hold.busy", busy, 1);
    in1 = 8'h11; in2 = 8'h11;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("hold.lat", n, W);
    chk("hold.res", {Bout, diff}, 0);
    @(negedge clk);
    chk("hold.gap", {busy, done}, 0);
    @(negedge clk);
    chk("hold.reaccept", busy, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("hold2.lat", n, W);
    chk("hold2.res", {Bout, diff}, 0);
    @(negedge clk);

    // reset after the 4th shift edge aborts without a done pulse
    @(negedge clk);
    in1 = 8'hA5; in2 = 8'h5A; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    d0 = dcnt;
    rst_n = 1'b0;
    #1;
    chk("abort.state", {busy, done, diff, Bout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort.nodone", dcnt - d0, 0);
    run_op(8'h10, 8'h01, 1'b0, "post", gd, gb);
    chk("post.res", {gb, gd}, {1'b0, 8'h0F});

    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      a  = W'($urandom);
      b  = W'($urandom);
      bi = 1'($urandom);
      run_op(a, b, bi, $sformatf("rnd%0d", i), gd, gb);
      exp = ref_sub(a, b, bi);
      chk($sformatf("rnd%0d.res", i), {gb, gd}, exp);
`ifdef SERSUB_OVF_EN
      chk($sformatf("rnd%0d.ovf", i), got_ov, ref_ovf(a, b, bi));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor: computes diff = in1 - in2 - Bin over WIDTH clock cycles, using one full-subtractor cell and a registered borrow.
- It is the inverse-operation counterpart of the team's full_adder cell.
- Used where area matters more than latency. Operand capture and completion use a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in1  input  WIDTH  minuend; captured on the accepted start edge
- in2  input  WIDTH  subtrahend; captured on the accepted start edge
- Bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  registered result; holds until the next accepted start
- Bout  output  1  final borrow-out; holds with diff

Behaviour:
- Reset:
  - Asynchronous: rst_n=0 forces state=IDLE and busy=0, done=0, diff=0, Bout=0, bit counter=0, internal operand registers=0.
  - Release is synchronous to clk.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: load a_sh<=in1, b_sh<=in2, borrow<=Bin, cnt<=0, go to SHIFT.
  - diff and Bout keep their previous values until the first SHIFT edge.
- SHIFT, one bit per edge:
  - d = a_sh[0]^b_sh[0]^borrow.
  - borrow_next = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
  - a_sh and b_sh shift right by 1.
  - diff shifts right with d entering at bit WIDTH-1.
  - cnt increments.
  - On the edge where cnt==WIDTH-1: Bout<=borrow_next, done<=1, go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=1.
  - Next edge: done<=0, go to IDLE.
- Latency:
  - Start accepted at edge k.
  - done is high in the cycle after edge k+WIDTH.
  - Back-to-back: earliest next acceptance at edge k+WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored with no effect. A level-held start re-triggers only once back in IDLE.
- Input changes after acceptance have no effect on the current operation.
- Arithmetic is modulo 2^WIDTH.
  - Bout=1 iff unsigned (in1 < in2+Bin).
  - Equivalently, {Bout,diff} equals the (WIDTH+1)-bit two's-complement value of in1-in2-Bin.
- Reset asserted mid-operation aborts immediately with no done pulse. The next operation after release is fully independent.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow flag.
  - Set on the final SHIFT edge: ovf<=(in1[MSB]!=in2[MSB]) && (d_final!=in1[MSB]), using the captured in1 MSB.
  - Reset value 0; holds with diff.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan (WIDTH=8):
- Simple subtract: in1=0x05, in2=0x03, Bin=0, start at edge k -> done high only in the cycle after edge k+8; diff=0x02, Bout=0; busy high for 9 cycles.
- Negative result: in1=0x03, in2=0x05, Bin=0 -> diff=0xFE, Bout=1. Then in1=0x00, in2=0x00, Bin=1 -> diff=0xFF, Bout=1.
- Held start: in1=0xFF, in2=0xFF, Bin=0 with start held high throughout, and in1/in2 changed to 0x11 during SHIFT -> diff=0x00, Bout=0. Second operation on 0x11-0x11 accepted at edge k+10.
- Reset mid-operation: start 0xA5-0x5A; drop rst_n for 1 cycle after the 4th SHIFT edge -> busy=0, done never pulses, diff=0, Bout=0. A following 0x10-0x01 gives diff=0x0F, Bout=0.
- Random/exhaustive: 256 random operand triples checked against the reference model {Bout,diff}=in1-in2-Bin; exactly one done pulse per start.
- SERSUB_OVF_EN defined: 0x80-0x01 -> diff=0x7F, ovf=1; 0x7F-0xFF -> diff=0x80, ovf=1; 0x10-0x01 -> ovf=0.
